// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - multi-cycle multiply/divide unit with private HI/LO registers
module hilo_muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 3,
    parameter int ENABLE_DIV = 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [4:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Stall,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [WIDTH-1:0] MulResult
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
    typedef enum logic [3:0] {
        OP_NONE, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO, OP_MULT, OP_MULTU,
        OP_DIV, OP_DIVU, OP_MADD, OP_MSUB, OP_MUL
    } op_t;

    localparam int CNT_MAX = (MUL_STAGES - 1 > WIDTH) ? MUL_STAGES - 1 : WIDTH;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t             state;
    op_t                op_q;
    op_t                dec_op;
    logic               busy_q;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   quo_q, rem_q, dvs_q;

    always_comb begin
        dec_op = OP_NONE;
        if (ALUOp == 5'b00000) begin
            case (Funct)
                6'b010000: dec_op = OP_MFHI;
                6'b010001: dec_op = OP_MTHI;
                6'b010010: dec_op = OP_MFLO;
                6'b010011: dec_op = OP_MTLO;
                6'b011000: dec_op = OP_MULT;
                6'b011001: dec_op = OP_MULTU;
                6'b011010: if (ENABLE_DIV != 0) dec_op = OP_DIV;
                6'b011011: if (ENABLE_DIV != 0) dec_op = OP_DIVU;
                default:   dec_op = OP_NONE;
            endcase
        end else if (ALUOp == 5'b01000) begin
            case (Funct)
                6'b000000: dec_op = OP_MADD;
                6'b000010: dec_op = OP_MUL;
                6'b000100: dec_op = OP_MSUB;
                default:   dec_op = OP_NONE;
            endcase
        end
    end

    assign Busy  = busy_q;
    assign Stall = Start & busy_q & (dec_op != OP_NONE);

    // Product is formed from the captured operands; only multu zero-extends.
    logic                 sgn_mul;
    logic [2*WIDTH-1:0]   ext_a, ext_b, prod, hilo;
    always_comb begin
        sgn_mul = (op_q != OP_MULTU);
        ext_a   = {{WIDTH{sgn_mul & a_q[WIDTH-1]}}, a_q};
        ext_b   = {{WIDTH{sgn_mul & b_q[WIDTH-1]}}, b_q};
        prod    = ext_a * ext_b;
        hilo    = {Hi, Lo};
    end

    // Restoring step: no borrow out of the trial subtraction means the bit is taken.
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               take;
    logic [WIDTH-1:0]   rem_nx, a_mag, b_mag, quo_fix, rem_fix;
    logic               a_neg, b_neg;
    always_comb begin
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, dvs_q};
        take     = ~rem_diff[WIDTH];
        rem_nx   = take ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        a_mag    = (dec_op == OP_DIV && A[WIDTH-1]) ? -A : A;
        b_mag    = (dec_op == OP_DIV && B[WIDTH-1]) ? -B : B;
        a_neg    = (op_q == OP_DIV) & a_q[WIDTH-1];
        b_neg    = (op_q == OP_DIV) & b_q[WIDTH-1];
        quo_fix  = (a_neg ^ b_neg) ? -quo_q : quo_q;
        rem_fix  = a_neg ? -rem_q : rem_q;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= S_IDLE;
            op_q      <= OP_NONE;
            busy_q    <= 1'b0;
            Done      <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            MulResult <= '0;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
        end else begin
            Done <= 1'b0;
            if (Flush) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (Start) begin
                            case (dec_op)
                                OP_MTHI: Hi <= A;
                                OP_MTLO: Lo <= A;
                                OP_MULT, OP_MULTU, OP_MADD, OP_MSUB, OP_MUL: begin
                                    op_q   <= dec_op;
                                    a_q    <= A;
                                    b_q    <= B;
                                    cnt    <= CW'(MUL_STAGES - 1);
                                    busy_q <= 1'b1;
                                    state  <= S_MUL;
                                end
                                OP_DIV, OP_DIVU: begin
                                    op_q   <= dec_op;
                                    a_q    <= A;
                                    b_q    <= B;
                                    quo_q  <= a_mag;
                                    dvs_q  <= b_mag;
                                    rem_q  <= '0;
                                    cnt    <= CW'(WIDTH);
                                    busy_q <= 1'b1;
                                    state  <= S_DIV;
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_MUL: begin
                        if (cnt == '0) begin
                            case (op_q)
                                OP_MULT, OP_MULTU: {Hi, Lo} <= prod;
                                OP_MADD:           {Hi, Lo} <= hilo + prod;
                                OP_MSUB:           {Hi, Lo} <= hilo - prod;
                                OP_MUL:            MulResult <= prod[WIDTH-1:0];
                                default: ;
                            endcase
                            Done   <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    S_DIV: begin
                        if (cnt != '0) begin
                            rem_q <= rem_nx;
                            quo_q <= {quo_q[WIDTH-2:0], take};
                            cnt   <= cnt - CW'(1);
                        end else begin
                            // Sign fixup; most-negative / -1 wraps to the required result naturally.
                            if (b_q == '0) begin
                                Hi <= a_q;
                                Lo <= '1;
                            end else begin
                                Hi <= rem_fix;
                                Lo <= quo_fix;
                            end
                            Done   <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - directed and randomized check of hilo_muldiv_unit against an arithmetic model
module tb_hilo_muldiv_unit;

    localparam int W  = 32;
    localparam int MS = 3;

    localparam logic [10:0] OP_MFHI  = {5'b00000, 6'b010000};
    localparam logic [10:0] OP_MTHI  = {5'b00000, 6'b010001};
    localparam logic [10:0] OP_MFLO  = {5'b00000, 6'b010010};
    localparam logic [10:0] OP_MTLO  = {5'b00000, 6'b010011};
    localparam logic [10:0] OP_MULT  = {5'b00000, 6'b011000};
    localparam logic [10:0] OP_MULTU = {5'b00000, 6'b011001};
    localparam logic [10:0] OP_DIV   = {5'b00000, 6'b011010};
    localparam logic [10:0] OP_DIVU  = {5'b00000, 6'b011011};
    localparam logic [10:0] OP_MADD  = {5'b01000, 6'b000000};
    localparam logic [10:0] OP_MUL   = {5'b01000, 6'b000010};
    localparam logic [10:0] OP_MSUB  = {5'b01000, 6'b000100};
    localparam logic [10:0] OP_ADD   = {5'b00000, 6'b100000};

    logic          Clk = 1'b0;
    logic          Rst, Start, Flush;
    logic [4:0]    ALUOp;
    logic [5:0]    Funct;
    logic [W-1:0]  A, B;
    logic          Stall, Busy, Done;
    logic [W-1:0]  Hi, Lo, MulResult;

    int compared   = 0;
    int mismatched = 0;
    logic [W-1:0] hi_m = '0, lo_m = '0, mr_m = '0;
    logic [10:0]  ops [9] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD,
                              OP_MSUB, OP_MUL, OP_MTHI, OP_MTLO};

    hilo_muldiv_unit #(.WIDTH(W), .MUL_STAGES(MS), .ENABLE_DIV(1)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .ALUOp(ALUOp), .Funct(Funct),
        .A(A), .B(B), .Flush(Flush), .Stall(Stall), .Busy(Busy), .Done(Done),
        .Hi(Hi), .Lo(Lo), .MulResult(MulResult)
    );

    always #5 Clk = ~Clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [10:0] code);
        ALUOp = code[10:6];
        Funct = code[5:0];
    endtask

    // Model computes the architectural result, then the DUT op is run and compared.
    task automatic run_op(input logic [10:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] hl;
        longint      sp;
        int          lat, n, sa, sb;
        bit          busy_ok;
        hl  = {hi_m, lo_m};
        sp  = longint'($signed(a)) * longint'($signed(b));
        lat = 0;
        case (code)
            OP_MTHI:  hi_m = a;
            OP_MTLO:  lo_m = a;
            OP_MULT:  begin lat = MS; {hi_m, lo_m} = sp; end
            OP_MULTU: begin lat = MS; {hi_m, lo_m} = {32'd0, a} * {32'd0, b}; end
            OP_MADD:  begin lat = MS; {hi_m, lo_m} = hl + sp; end
            OP_MSUB:  begin lat = MS; {hi_m, lo_m} = hl - sp; end
            OP_MUL:   begin lat = MS; mr_m = sp[31:0]; end
            OP_DIV: begin
                lat = W + 1;
                if (b == 0) begin hi_m = a; lo_m = '1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo_m = 32'h8000_0000; hi_m = 0; end
                else begin sa = $signed(a); sb = $signed(b); lo_m = sa / sb; hi_m = sa % sb; end
            end
            OP_DIVU: begin
                lat = W + 1;
                if (b == 0) begin hi_m = a; lo_m = '1; end
                else begin lo_m = a / b; hi_m = a % b; end
            end
            default: ;
        endcase
        @(negedge Clk);
        Start = 1'b1;
        set_op(code);
        A = a;
        B = b;
        #1 chk1("stall_idle", Stall, 1'b0);
        @(posedge Clk);
        #1;
        Start = 1'b0;
        A = $urandom;
        B = $urandom;
        if (lat == 0) begin
            chk1("move_busy", Busy, 1'b0);
            chk1("move_done", Done, 1'b0);
        end else begin
            n = 0;
            busy_ok = 1'b1;
            while (Done !== 1'b1 && n < 100) begin
                if (Busy !== 1'b1) busy_ok = 1'b0;
                @(posedge Clk);
                #1;
                n++;
            end
            chk1("busy_while_running", busy_ok, 1'b1);
            chki("latency", n, lat);
            chk1("busy_at_done", Busy, 1'b0);
        end
        chkw("hi", Hi, hi_m);
        chkw("lo", Lo, lo_m);
        chkw("mulresult", MulResult, mr_m);
        if (lat != 0) begin
            @(posedge Clk);
            #1 chk1("done_one_cycle", Done, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen, stall_ok;
        logic [10:0] code;
        logic [W-1:0] ra, rb;
        Rst = 1'b0; Start = 1'b0; Flush = 1'b0; ALUOp = '0; Funct = '0; A = '0; B = '0;
        repeat (2) @(posedge Clk);
        #1;
        chkw("rst_hi", Hi, '0);
        chkw("rst_lo", Lo, '0);
        chkw("rst_mulresult", MulResult, '0);
        chk1("rst_busy", Busy, 1'b0);
        chk1("rst_done", Done, 1'b0);
        @(negedge Clk);
        Rst = 1'b1;

        run_op(OP_MULT, -32'sd3, 32'd5);
        chkw("mult_hi_const", Hi, 32'hFFFF_FFFF);
        chkw("mult_lo_const", Lo, 32'hFFFF_FFF1);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        chkw("multu_hi_const", Hi, 32'h0000_0001);
        chkw("multu_lo_const", Lo, 32'hFFFF_FFFE);
        run_op(OP_MTLO, 32'd10, 32'd0);
        run_op(OP_MTHI, 32'd0, 32'd0);
        run_op(OP_MADD, 32'd4, 32'hFFFF_FFFF);
        chkw("madd_lo_const", Lo, 32'h0000_0006);
        run_op(OP_MTLO, 32'd0, 32'd0);
        run_op(OP_MSUB, 32'd2, 32'd3);
        chkw("msub_hi_const", Hi, 32'hFFFF_FFFF);
        chkw("msub_lo_const", Lo, 32'hFFFF_FFFA);
        run_op(OP_DIV, -32'sd7, 32'd2);
        chkw("div_lo_const", Lo, 32'hFFFF_FFFD);
        chkw("div_hi_const", Hi, 32'hFFFF_FFFF);
        run_op(OP_DIVU, 32'd7, 32'd0);
        chkw("divz_hi_const", Hi, 32'h0000_0007);
        chkw("divz_lo_const", Lo, 32'hFFFF_FFFF);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chkw("divovf_lo_const", Lo, 32'h8000_0000);
        run_op(OP_MUL, 32'd6, 32'd7);
        chkw("mul_const", MulResult, 32'h0000_002A);

        // mflo held with Start while a divide runs must stall every cycle
        @(negedge Clk);
        Start = 1'b1; set_op(OP_DIVU); A = 32'd100; B = 32'd7;
        hi_m = 32'd2; lo_m = 32'd14;
        @(posedge Clk);
        #1;
        set_op(OP_MFLO);
        n = 0; stall_ok = 1'b1;
        while (Done !== 1'b1 && n < 100) begin
            if (Stall !== 1'b1) stall_ok = 1'b0;
            @(posedge Clk);
            #1;
            n++;
        end
        chk1("stall_while_busy", stall_ok, 1'b1);
        chki("stall_div_latency", n, W + 1);
        chk1("stall_released", Stall, 1'b0);
        chkw("stall_div_lo", Lo, lo_m);
        chkw("stall_div_hi", Hi, hi_m);
        Start = 1'b0;

        run_op(OP_MTHI, 32'h1234_5678, 32'd0);
        run_op(OP_MTLO, 32'h9ABC_DEF0, 32'd0);

        // Flush on the second cycle of a mult
        @(negedge Clk);
        Start = 1'b1; set_op(OP_MULT); A = 32'd123; B = 32'd456;
        @(posedge Clk);
        #1 Start = 1'b0;
        @(posedge Clk);
        #1 Flush = 1'b1;
        @(posedge Clk);
        #1 Flush = 1'b0;
        chk1("flush_busy", Busy, 1'b0);
        seen = 1'b0;
        repeat (MS + 2) begin
            if (Done === 1'b1) seen = 1'b1;
            @(posedge Clk);
            #1;
        end
        chk1("flush_no_done", seen, 1'b0);
        chkw("flush_hi", Hi, hi_m);
        chkw("flush_lo", Lo, lo_m);

        // Flush together with Start: nothing accepted
        @(negedge Clk);
        Start = 1'b1; Flush = 1'b1; set_op(OP_MULT); A = 32'd9; B = 32'd9;
        @(posedge Clk);
        #1;
        Start = 1'b0; Flush = 1'b0;
        chk1("flush_start_busy", Busy, 1'b0);
        @(negedge Clk);
        Start = 1'b1; Flush = 1'b1; set_op(OP_MTHI); A = 32'hDEAD_BEEF;
        @(posedge Clk);
        #1;
        Start = 1'b0; Flush = 1'b0;
        seen = 1'b0;
        repeat (MS + 2) begin
            if (Done === 1'b1) seen = 1'b1;
            @(posedge Clk);
            #1;
        end
        chk1("flush_start_no_done", seen, 1'b0);
        chkw("flush_start_hi", Hi, hi_m);
        chkw("flush_start_lo", Lo, lo_m);

        // Unsupported op is ignored
        @(negedge Clk);
        Start = 1'b1; set_op(OP_ADD); A = 32'd1; B = 32'd2;
        @(posedge Clk);
        #1 Start = 1'b0;
        chk1("unsup_busy", Busy, 1'b0);
        chk1("unsup_done", Done, 1'b0);
        chkw("unsup_hi", Hi, hi_m);

        // Asynchronous reset in the middle of a divide
        @(negedge Clk);
        Start = 1'b1; set_op(OP_DIVU); A = 32'd1000; B = 32'd3;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (9) @(posedge Clk);
        #1 Rst = 1'b0;
        #1;
        chk1("rstdiv_busy", Busy, 1'b0);
        chk1("rstdiv_done", Done, 1'b0);
        chkw("rstdiv_hi", Hi, '0);
        chkw("rstdiv_lo", Lo, '0);
        hi_m = '0; lo_m = '0; mr_m = '0;
        @(negedge Clk);
        Rst = 1'b1;
        seen = 1'b0;
        repeat (W + 4) begin
            @(posedge Clk);
            #1;
            if (Done === 1'b1) seen = 1'b1;
        end
        chk1("rstdiv_no_done", seen, 1'b0);
        run_op(OP_MULT, 32'd9, -32'sd2);

        for (int i = 0; i < 24; i++) begin
            code = ops[$urandom_range(0, 8)];
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            run_op(code, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
